// File: rtl/lsu_if.sv
// Data-memory request/response bus between the load/store unit and the memory port.
// The master side issues one 64-bit-aligned beat; responses are always accepted.
interface lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/lsu.sv
// Multi-cycle load/store unit: one aligned 64-bit bus beat per operation, extended load data.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       ld_type,
    input  logic [3:0]       st_type,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] st_data,
    lsu_if.master            mem,
    output logic             done,
    output logic [WIDTH-1:0] ld_data,
    output logic             ex,
    output logic [62:0]      ecode
);

    localparam logic [62:0] ECODE_NONE   = 63'd64;
    localparam logic [62:0] ECODE_LD_MIS = 63'd4;
    localparam logic [62:0] ECODE_ST_MIS = 63'd6;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t state_reg, state_next;

    // Operation latched on accept: size is log2(bytes)
    logic       load_reg, load_next;
    logic       uns_reg, uns_next;
    logic [1:0] size_reg, size_next;
    logic [2:0] off_reg, off_next;

    logic             req_ready_reg, req_ready_next;
    logic             mem_req_valid_reg, mem_req_valid_next;
    logic [63:0]      mem_req_addr_reg, mem_req_addr_next;
    logic             mem_req_wen_reg, mem_req_wen_next;
    logic [63:0]      mem_req_wdata_reg, mem_req_wdata_next;
    logic [7:0]       mem_req_wmask_reg, mem_req_wmask_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] ld_data_reg, ld_data_next;
    logic             ex_reg, ex_next;
    logic [62:0]      ecode_reg, ecode_next;

    // Decode of the offered request
    logic        acc_load;
    logic        acc_uns;
    logic [1:0]  acc_size;
    logic [2:0]  acc_off;
    logic        trap;
    logic [7:0]  size_mask;
    logic [63:0] addr64;
    logic [63:0] st64;
    logic [63:0] wdata_shift;
    logic [7:0]  wmask_shift;
    logic [63:0] rsp_shift;
    logic [63:0] load_ext;

    assign addr64  = 64'(addr);
    assign st64    = 64'(st_data);
    assign acc_off = addr[2:0];

    // A nonzero load vector wins over a simultaneous store; highest set bit wins within a vector
    always_comb begin
        acc_load = |ld_type;
        acc_uns  = 1'b0;
        acc_size = 2'd0;
        if (acc_load) begin
            if (ld_type[6])      acc_size = 2'd0;
            else if (ld_type[5]) acc_size = 2'd1;
            else if (ld_type[4]) acc_size = 2'd2;
            else if (ld_type[3]) acc_size = 2'd3;
            else if (ld_type[2]) begin acc_size = 2'd0; acc_uns = 1'b1; end
            else if (ld_type[1]) begin acc_size = 2'd1; acc_uns = 1'b1; end
            else                 begin acc_size = 2'd2; acc_uns = 1'b1; end
        end else begin
            if (st_type[3])      acc_size = 2'd0;
            else if (st_type[2]) acc_size = 2'd1;
            else if (st_type[1]) acc_size = 2'd2;
            else                 acc_size = 2'd3;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        case (acc_size)
            2'd0:    trap = 1'b0;
            2'd1:    trap = acc_off[0];
            2'd2:    trap = |acc_off[1:0];
            default: trap = |acc_off;
        endcase
    end
`else
    assign trap = 1'b0;
`endif

    // Lanes shifted past byte 7 fall off the top of the beat
    always_comb begin
        case (acc_size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        wmask_shift = size_mask << acc_off;
        wdata_shift = st64 << {acc_off, 3'b000};
    end

    always_comb begin
        rsp_shift = mem.mem_rsp_rdata >> {off_reg, 3'b000};
        case (size_reg)
            2'd0: load_ext = uns_reg ? {56'b0, rsp_shift[7:0]}
                                     : {{56{rsp_shift[7]}}, rsp_shift[7:0]};
            2'd1: load_ext = uns_reg ? {48'b0, rsp_shift[15:0]}
                                     : {{48{rsp_shift[15]}}, rsp_shift[15:0]};
            2'd2: load_ext = uns_reg ? {32'b0, rsp_shift[31:0]}
                                     : {{32{rsp_shift[31]}}, rsp_shift[31:0]};
            default: load_ext = rsp_shift;
        endcase
    end

    always_comb begin
        state_next         = state_reg;
        load_next          = load_reg;
        uns_next           = uns_reg;
        size_next          = size_reg;
        off_next           = off_reg;
        mem_req_valid_next = mem_req_valid_reg;
        mem_req_addr_next  = mem_req_addr_reg;
        mem_req_wen_next   = mem_req_wen_reg;
        mem_req_wdata_next = mem_req_wdata_reg;
        mem_req_wmask_next = mem_req_wmask_reg;
        done_next          = 1'b0;
        ex_next            = 1'b0;
        ecode_next         = ECODE_NONE;
        ld_data_next       = ld_data_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid && (acc_load || (|st_type))) begin
                    load_next = acc_load;
                    uns_next  = acc_uns;
                    size_next = acc_size;
                    off_next  = acc_off;
                    if (trap) begin
                        state_next   = RESP;
                        done_next    = 1'b1;
                        ex_next      = 1'b1;
                        ecode_next   = acc_load ? ECODE_LD_MIS : ECODE_ST_MIS;
                        ld_data_next = '0;
                    end else begin
                        state_next         = REQ;
                        mem_req_valid_next = 1'b1;
                        mem_req_addr_next  = {addr64[63:3], 3'b000};
                        mem_req_wen_next   = ~acc_load;
                        mem_req_wdata_next = acc_load ? 64'd0 : wdata_shift;
                        mem_req_wmask_next = acc_load ? 8'd0 : wmask_shift;
                    end
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    state_next         = WAIT;
                    mem_req_valid_next = 1'b0;
                end
            end
            WAIT: begin
                if (mem.mem_rsp_valid) begin
                    state_next   = RESP;
                    done_next    = 1'b1;
                    ld_data_next = load_reg ? WIDTH'(load_ext) : '0;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        req_ready_next = (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            load_reg          <= 1'b0;
            uns_reg           <= 1'b0;
            size_reg          <= 2'd0;
            off_reg           <= 3'd0;
            req_ready_reg     <= 1'b1;
            mem_req_valid_reg <= 1'b0;
            mem_req_addr_reg  <= 64'd0;
            mem_req_wen_reg   <= 1'b0;
            mem_req_wdata_reg <= 64'd0;
            mem_req_wmask_reg <= 8'd0;
            done_reg          <= 1'b0;
            ld_data_reg       <= '0;
            ex_reg            <= 1'b0;
            ecode_reg         <= ECODE_NONE;
        end else begin
            state_reg         <= state_next;
            load_reg          <= load_next;
            uns_reg           <= uns_next;
            size_reg          <= size_next;
            off_reg           <= off_next;
            req_ready_reg     <= req_ready_next;
            mem_req_valid_reg <= mem_req_valid_next;
            mem_req_addr_reg  <= mem_req_addr_next;
            mem_req_wen_reg   <= mem_req_wen_next;
            mem_req_wdata_reg <= mem_req_wdata_next;
            mem_req_wmask_reg <= mem_req_wmask_next;
            done_reg          <= done_next;
            ld_data_reg       <= ld_data_next;
            ex_reg            <= ex_next;
            ecode_reg         <= ecode_next;
        end
    end

    assign req_ready         = req_ready_reg;
    assign mem.mem_req_valid = mem_req_valid_reg;
    assign mem.mem_req_addr  = mem_req_addr_reg;
    assign mem.mem_req_wen   = mem_req_wen_reg;
    assign mem.mem_req_wdata = mem_req_wdata_reg;
    assign mem.mem_req_wmask = mem_req_wmask_reg;
    assign done              = done_reg;
    assign ld_data           = ld_data_reg;
    assign ex                = ex_reg;
    assign ecode             = ecode_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a byte-level reference model predicts each bus beat and result,
// one compare process checks them every cycle, and literal values pin the model.
module tb_lsu;

    typedef struct {
        logic        issue;
        logic        wen;
        logic [63:0] maddr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] ld;
        logic        ex;
        logic [62:0] ecode;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  ld_type = '0;
    logic [3:0]  st_type = '0;
    logic [63:0] addr = '0;
    logic [63:0] st_data = '0;
    logic        done;
    logic [63:0] ld_data;
    logic        ex;
    logic [62:0] ecode;

    lsu_if mem();

    lsu #(.WIDTH(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .ld_type  (ld_type),
        .st_type  (st_type),
        .addr     (addr),
        .st_data  (st_data),
        .mem      (mem),
        .done     (done),
        .ld_data  (ld_data),
        .ex       (ex),
        .ecode    (ecode)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   op_id = 0;
    int   done_cnt = 0;
    exp_t cur;
    logic [7:0]  last_wmask;
    logic [63:0] last_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // op index: 0 lb,1 lh,2 lw,3 ld,4 lbu,5 lhu,6 lwu,7 sb,8 sh,9 sw,10 sd
    function automatic exp_t model(input int op, input logic [63:0] a, input logic [63:0] sd,
                                   input logic [63:0] rd);
        exp_t e;
        int bytes, off;
        bit is_ld, sgn, mis;
        logic [63:0] msk, v;
        is_ld = (op < 7);
        sgn   = (op < 3);
        bytes = is_ld ? (1 << (op % 4)) : (1 << (op - 7));
        off   = int'(a[2:0]);
        mis   = (off % bytes) != 0;
`ifndef LSU_MISALIGN_CHECK_EN
        mis = 1'b0;
`endif
        e.issue = !mis;
        e.wen   = !is_ld;
        e.maddr = {a[63:3], 3'b000};
        e.wmask = is_ld ? 8'd0 : 8'(((1 << bytes) - 1) << off);
        e.wdata = is_ld ? 64'd0 : (sd << (8 * off));
        msk = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
        v = (rd >> (8 * off)) & msk;
        if (sgn && v[8 * bytes - 1]) v = v | ~msk;
        e.ld    = (is_ld && !mis) ? v : 64'd0;
        e.ex    = mis;
        e.ecode = mis ? (is_ld ? 63'd4 : 63'd6) : 63'd64;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (mem.mem_req_valid) begin
                if (!cur.issue) chk("unexpected_req", 64'(mem.mem_req_valid), 64'(cur.issue));
                else begin
                    chk("req_addr",  mem.mem_req_addr, cur.maddr);
                    chk("req_wen",   64'(mem.mem_req_wen), 64'(cur.wen));
                    chk("req_wdata", mem.mem_req_wdata, cur.wdata);
                    chk("req_wmask", 64'(mem.mem_req_wmask), 64'(cur.wmask));
                end
            end
            if (done) begin
                if (done_cnt >= op_id) chk("unexpected_done", 64'(done), 64'd0);
                else begin
                    chk("ld_data", ld_data, cur.ld);
                    chk("ex", 64'(ex), 64'(cur.ex));
                    chk("ecode", 64'(ecode), 64'(cur.ecode));
                end
                done_cnt++;
            end else begin
                chk("ex_quiet", 64'(ex), 64'd0);
                chk("ecode_quiet", 64'(ecode), 64'd64);
            end
        end
    end

    task automatic run_op(input int op, input logic [63:0] a, input logic [63:0] sd,
                          input logic [63:0] rd, input int stall, input logic [6:0] xld,
                          input logic [3:0] xst, input string tag);
        int  stalls;
        int  lat;
        bit  rsp_next;
        bit  seen;
        @(negedge clk);
        cur = model(op, a, sd, rd);
        lat = cur.issue ? 3 + stall : 1;
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        ld_type   = (op < 7 ? 7'(1 << (6 - op)) : 7'd0) | xld;
        st_type   = (op >= 7 ? 4'(1 << (10 - op)) : 4'd0) | xst;
        addr      = a;
        st_data   = sd;
        op_id++;
        stalls = 0;
        rsp_next = 1'b0;
        seen = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            ld_type = '0;
            st_type = '0;
            mem.mem_rsp_valid = rsp_next;
            mem.mem_rsp_rdata = rsp_next ? rd : 64'hDEAD_BEEF_0BAD_F00D;
            rsp_next = 1'b0;
            mem.mem_req_ready = 1'b0;
            if (mem.mem_req_valid) begin
                last_wmask = mem.mem_req_wmask;
                last_wdata = mem.mem_req_wdata;
                if (stalls < stall) begin
                    stalls++;
                    mem.mem_rsp_valid = 1'b1;
                end else begin
                    mem.mem_req_ready = 1'b1;
                    rsp_next = 1'b1;
                end
            end
            if (done) begin
                seen = 1'b1;
                chk({tag, "_latency"}, 64'(k), 64'(lat));
            end
        end
        if (!seen) chk({tag, "_done_timeout"}, 64'(done), 64'd1);
        $display("op %s addr=%h st=%h rd=%h -> ld_data=%h ex=%0d ecode=%0d",
                 tag, a, sd, rd, ld_data, ex, ecode);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_mem_req_valid"}, 64'(mem.mem_req_valid), 64'd0);
        chk({tag, "_wen"}, 64'(mem.mem_req_wen), 64'd0);
        chk({tag, "_addr"}, mem.mem_req_addr, 64'd0);
        chk({tag, "_wdata"}, mem.mem_req_wdata, 64'd0);
        chk({tag, "_wmask"}, 64'(mem.mem_req_wmask), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_ld_data"}, ld_data, 64'd0);
        chk({tag, "_ex"}, 64'(ex), 64'd0);
        chk({tag, "_ecode"}, 64'(ecode), 64'd64);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        mem.mem_req_ready = 1'b0;
        mem.mem_rsp_valid = 1'b0;
        mem.mem_rsp_rdata = 64'd0;
        cur = model(3, 64'd0, 64'd0, 64'd0);
        cur.issue = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        run_op(0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 7'd0, 4'd0, "lb");
        chk("lb_lit", ld_data, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(4, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 7'd0, 4'd0, "lbu");
        chk("lbu_lit", ld_data, 64'h80);
        run_op(8, 64'h8000_0006, 64'h1234, 64'd0, 0, 7'd0, 4'd0, "sh");
        chk("sh_lit_ld", ld_data, 64'd0);
        chk("sh_lit_wmask", 64'(last_wmask), 64'hC0);
        chk("sh_lit_wdata", last_wdata, 64'h1234_0000_0000_0000);
        run_op(2, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 0, 7'd0, 4'd0, "lw");
        chk("lw_lit", ld_data, 64'hFFFF_FFFF_8765_4321);
        run_op(6, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 0, 7'd0, 4'd0, "lwu");
        chk("lwu_lit", ld_data, 64'h8765_4321);
        run_op(1, 64'h8000_0002, 64'd0, 64'h0000_0000_8001_0000, 0, 7'd0, 4'd0, "lh");
        chk("lh_lit", ld_data, 64'hFFFF_FFFF_FFFF_8001);
        run_op(5, 64'h8000_0002, 64'd0, 64'h0000_0000_8001_0000, 0, 7'd0, 4'd0, "lhu");
        run_op(3, 64'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 7'd0, 4'd0, "ld");
        chk("ld_lit", ld_data, 64'h0123_4567_89AB_CDEF);
        run_op(9, 64'h8000_0010, 64'hCAFE_BABE, 64'd0, 3, 7'd0, 4'd0, "sw_stall");
        chk("sw_stall_lit_wmask", 64'(last_wmask), 64'h0F);
        run_op(5, 64'h8000_0006, 64'd0, 64'hBEEF_0000_0000_0000, 0, 7'd0, 4'b0001, "ld_and_st");
        chk("ld_and_st_lit", ld_data, 64'hBEEF);
        run_op(0, 64'h8000_0001, 64'd0, 64'h0000_0000_0000_7F00, 0, 7'b0001001, 4'd0, "ld_multi");
        chk("ld_multi_lit", ld_data, 64'h7F);
        run_op(7, 64'h8000_0005, 64'hAB, 64'd0, 0, 7'd0, 4'b0011, "st_multi");
        chk("st_multi_lit_wmask", 64'(last_wmask), 64'h20);

        run_op(3, 64'h8000_0004, 64'd0, 64'h1122_3344_5566_7788, 0, 7'd0, 4'd0, "ld_mis");
`ifdef LSU_MISALIGN_CHECK_EN
        chk("ld_mis_lit_ecode", 64'(ecode), 64'd4);
`else
        chk("ld_mis_lit", ld_data, 64'h1122_3344);
`endif
        run_op(9, 64'h8000_0002, 64'hAABB_CCDD, 64'd0, 0, 7'd0, 4'd0, "sw_mis");
`ifdef LSU_MISALIGN_CHECK_EN
        chk("sw_mis_lit_ecode", 64'(ecode), 64'd6);
`else
        chk("sw_mis_lit_wmask", 64'(last_wmask), 64'h3C);
        chk("sw_mis_lit_wdata", last_wdata, 64'h0000_AABB_CCDD_0000);
`endif
        run_op(10, 64'h8000_0004, 64'h0102_0304_0506_0708, 64'd0, 0, 7'd0, 4'd0, "sd_mis");

        // All-zero type vectors must be ignored
        @(negedge clk);
        cur.issue = 1'b0;
        req_valid = 1'b1;
        addr = 64'h8000_0040;
        repeat (3) begin
            @(negedge clk);
            chk("ignored_req_ready", 64'(req_ready), 64'd1);
            chk("ignored_mem_valid", 64'(mem.mem_req_valid), 64'd0);
        end
        req_valid = 1'b0;
        $display("op ignored_zero_type req_ready=%0d", req_ready);

        // Reset while waiting for the response; the late response must be dropped
        @(negedge clk);
        cur = model(2, 64'h8000_0020, 64'd0, 64'd0);
        req_valid = 1'b1;
        ld_type = 7'b0010000;
        addr = 64'h8000_0020;
        @(negedge clk);
        req_valid = 1'b0;
        ld_type = '0;
        chk("rst_seq_req_valid", 64'(mem.mem_req_valid), 64'd1);
        mem.mem_req_ready = 1'b1;
        @(negedge clk);
        mem.mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("after_rst");
        mem.mem_rsp_valid = 1'b1;
        mem.mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            mem.mem_rsp_valid = 1'b0;
            chk("after_rst_no_done", 64'(done), 64'd0);
            chk("after_rst_req_ready", 64'(req_ready), 64'd1);
        end
        $display("op reset_in_wait done=%0d req_ready=%0d", done, req_ready);
        run_op(10, 64'h8000_0018, 64'h0102_0304_0506_0708, 64'd0, 0, 7'd0, 4'd0, "sd_after_rst");
        chk("sd_after_rst_lit_wmask", 64'(last_wmask), 64'hFF);
        chk("sd_after_rst_lit_ld", ld_data, 64'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
